// File: rtl/reg_file_sb.sv
// reg_file_sb: r0-r7 register file with issue scoreboard. Writes show on q the next cycle; iss_ready stalls issue, wb always accepted.
// Define REG_FILE_SB_BYPASS_EN to forward wb_data to q and to drop the written register from iss_ready in the writeback cycle.
module reg_file_sb #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iss_valid,
   input  logic              iss_wr,
   input  logic [2:0]        iss_dst,
   input  logic [2:0]        iss_src_a,
   input  logic [2:0]        iss_src_b,
   output logic              iss_ready,
   input  logic              wb_valid,
   input  logic [2:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [NREG-1:0]   busy,
   output logic [DATA_W-1:0] q0,
   output logic [DATA_W-1:0] q1,
   output logic [DATA_W-1:0] q2,
   output logic [DATA_W-1:0] q3,
   output logic [DATA_W-1:0] q4,
   output logic [DATA_W-1:0] q5,
   output logic [DATA_W-1:0] q6,
   output logic [DATA_W-1:0] q7
);

   logic [NREG-1:0][DATA_W-1:0] regs;
   logic [NREG-1:0][DATA_W-1:0] rd_dat;
   logic [NREG-1:0]             busy_q;
   logic [NREG-1:0]             busy_nxt;
   logic [NREG-1:0]             busy_eff;
   logic                        wb_vld;
   logic                        iss_fire;

   assign wb_vld   = wb_valid && (wb_addr != 3'd0);
   assign iss_fire = iss_valid && iss_ready;

   always_comb begin
      busy_eff = busy_q;
`ifdef REG_FILE_SB_BYPASS_EN
      if (wb_vld)
         busy_eff[wb_addr] = 1'b0;
`endif
      iss_ready = !(busy_eff[iss_src_a] || busy_eff[iss_src_b] || (iss_wr && busy_eff[iss_dst]));
   end

   // Clear before set so a same-edge issue to the written register keeps it reserved.
   always_comb begin
      busy_nxt = busy_q;
      if (wb_vld)
         busy_nxt[wb_addr] = 1'b0;
      if (iss_fire && iss_wr)
         busy_nxt[iss_dst] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         regs   <= '0;
         busy_q <= '0;
      end else begin
         busy_q <= busy_nxt;
         if (wb_vld)
            regs[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      rd_dat    = regs;
      rd_dat[0] = '0;
`ifdef REG_FILE_SB_BYPASS_EN
      if (wb_vld)
         rd_dat[wb_addr] = wb_data;
`endif
   end

   assign busy = busy_q;
   assign q0   = '0;
   assign q1   = rd_dat[1];
   assign q2   = rd_dat[2];
   assign q3   = rd_dat[3];
   assign q4   = rd_dat[4];
   assign q5   = rd_dat[5];
   assign q6   = rd_dat[6];
   assign q7   = rd_dat[7];

endmodule
